// File: rtl/hamming_22_16_pkg.sv
// Shared definitions for the 22/16 Hamming SEC-DED encoder/decoder pair:
// widths, check-bit positions, buffer state encoding and the data->codeword map.
package hamming_22_16_pkg;

    localparam int DATA_W  = 16;
    localparam int CODE_W  = 22;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 2;

    // Bit positions of the overall parity bit and the Hamming check bits.
    localparam int POS_P0  = 0;
    localparam int POS_C1  = 1;
    localparam int POS_C2  = 2;
    localparam int POS_C4  = 4;
    localparam int POS_C8  = 8;
    localparam int POS_C16 = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] codeword_t;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // Map a data word onto the codeword layout the decoder extracts from.
    function automatic codeword_t hamming_encode(input data_t d);
        codeword_t cw;
        cw         = {CODE_W{1'b0}};
        cw[3]      = d[0];
        cw[7:5]    = d[3:1];
        cw[15:9]   = d[10:4];
        cw[21:17]  = d[15:11];
        cw[POS_C1]  = ^{cw[3], cw[5], cw[7], cw[9], cw[11], cw[13], cw[15],
                        cw[17], cw[19], cw[21]};
        cw[POS_C2]  = ^{cw[3], cw[6], cw[7], cw[10], cw[11], cw[14], cw[15],
                        cw[18], cw[19]};
        cw[POS_C4]  = ^{cw[5], cw[6], cw[7], cw[12], cw[13], cw[14], cw[15],
                        cw[20], cw[21]};
        cw[POS_C8]  = ^cw[15:9];
        cw[POS_C16] = ^cw[21:17];
        // Overall parity covers every other bit, check bits included.
        cw[POS_P0]  = ^cw[21:1];
        return cw;
    endfunction

endpackage

// File: rtl/h_enc_fifo2.sv
// Generic 2-entry valid/ready buffer. The head entry drives the output
// directly from a register; input ready depends only on occupancy, so there
// is no combinational path from out_ready_i to in_ready_o.
module h_enc_fifo2
    import hamming_22_16_pkg::*;
#(
    parameter int W = 22
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    fifo_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push_s;
    logic         pop_s;

    assign push_s      = in_valid_i && (state_q != FIFO_FULL);
    assign pop_s       = out_ready_i && (state_q != FIFO_EMPTY);
    assign in_ready_o  = (state_q != FIFO_FULL);
    assign out_valid_o = (state_q != FIFO_EMPTY);
    assign out_data_o  = head_q;

    // Occupancy state and storage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FIFO_EMPTY;
            head_q  <= {W{1'b0}};
            tail_q  <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next occupancy and data movement; the head always holds the oldest word.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            FIFO_EMPTY: begin
                if (push_s) begin
                    head_d  = in_data_i;
                    state_d = FIFO_ONE;
                end else begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_ONE: begin
                case ({push_s, pop_s})
                    2'b10: begin
                        tail_d  = in_data_i;
                        state_d = FIFO_FULL;
                    end
                    2'b01: begin
                        state_d = FIFO_EMPTY;
                    end
                    2'b11: begin
                        head_d  = in_data_i;
                        state_d = FIFO_ONE;
                    end
                    default: begin
                        state_d = FIFO_ONE;
                    end
                endcase
            end
            FIFO_FULL: begin
                // No push is possible here: in_ready_o is low while full.
                if (pop_s) begin
                    head_d  = tail_q;
                    state_d = FIFO_ONE;
                end else begin
                    state_d = FIFO_FULL;
                end
            end
            default: begin
                state_d = FIFO_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/h_encoder_22_16.sv
// Streaming 22/16 Hamming SEC-DED encoder with a 2-entry output buffer and a
// running count of emitted codewords.
// Optional error injection is built when HENC_ERR_INJECT_EN is defined; it
// adds i_InjMask/i_InjArm and XORs a latched mask into the next accepted word.
module h_encoder_22_16
    import hamming_22_16_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] i_DataWord,
    input  logic              i_Valid,
    output logic              o_Ready,
    output logic [CODE_W-1:0] o_CodeWord,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [CNT_W-1:0]  o_WordCnt
`ifdef HENC_ERR_INJECT_EN
    ,
    input  logic [CODE_W-1:0] i_InjMask,
    input  logic              i_InjArm
`endif
);

    codeword_t            enc_s;
    codeword_t            inj_mask_s;
    logic                 accept_s;
    logic                 emit_s;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;

    assign accept_s = i_Valid && o_Ready;
    assign emit_s   = o_Valid && i_Ready;
    assign enc_s    = hamming_encode(i_DataWord) ^ inj_mask_s;

`ifdef HENC_ERR_INJECT_EN
    logic      armed_q, armed_d;
    codeword_t mask_q,  mask_d;

    // Arm/consume the injection mask; an arm in the accept cycle applies directly.
    always_comb begin
        armed_d    = armed_q;
        mask_d     = mask_q;
        inj_mask_s = {CODE_W{1'b0}};
        if (i_InjArm) begin
            inj_mask_s = i_InjMask;
        end else if (armed_q) begin
            inj_mask_s = mask_q;
        end else begin
            inj_mask_s = {CODE_W{1'b0}};
        end
        if (accept_s) begin
            armed_d = 1'b0;
        end else if (i_InjArm) begin
            armed_d = 1'b1;
            mask_d  = i_InjMask;
        end else begin
            armed_d = armed_q;
        end
    end

    // Injection flag and mask registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            armed_q <= 1'b0;
            mask_q  <= {CODE_W{1'b0}};
        end else begin
            armed_q <= armed_d;
            mask_q  <= mask_d;
        end
    end
`else
    assign inj_mask_s = {CODE_W{1'b0}};
`endif

    h_enc_fifo2 #(
        .W (CODE_W)
    ) u_fifo (
        .clk_i       (i_Clk),
        .rst_i       (i_Rst),
        .in_data_i   (enc_s),
        .in_valid_i  (i_Valid),
        .in_ready_o  (o_Ready),
        .out_data_o  (o_CodeWord),
        .out_valid_o (o_Valid),
        .out_ready_i (i_Ready)
    );

    // Count output transfers; wraps naturally at the counter width.
    always_comb begin
        if (emit_s) begin
            word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Output transfer counter register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            word_cnt_q <= {CNT_W{1'b0}};
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign o_WordCnt = word_cnt_q;

endmodule

// File: tb/tb_h_encoder_22_16.sv
// Self-checking bench for h_encoder_22_16: directed vectors, back-pressure,
// reset mid-stream and a randomized stream against a positional Hamming model.
module tb_h_encoder_22_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [21:0] cw_out;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] cnt_out;
    logic [21:0] inj_mask;
    logic        inj_arm;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] data;
        logic [21:0] cw;
        logic        clean;
    } exp_t;

    exp_t        sb[$];
    bit          mon_en = 1'b0;
    int          xfers  = 0;
    logic        pend   = 1'b0;
    logic [21:0] pmask  = 22'h0;

    always #5 clk = ~clk;

    h_encoder_22_16 dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_DataWord (data_in),
        .i_Valid    (valid_in),
        .o_Ready    (ready_out),
        .o_CodeWord (cw_out),
        .o_Valid    (valid_out),
        .i_Ready    (ready_in),
        .o_WordCnt  (cnt_out)
`ifdef HENC_ERR_INJECT_EN
        ,
        .i_InjMask  (inj_mask),
        .i_InjArm   (inj_arm)
`endif
    );

    // Generic Hamming: data fills non-power-of-two positions 1..21 in order;
    // check bit 2^j is even parity over positions having bit j set.
    function automatic logic [21:0] ref_encode(input logic [15:0] d);
        logic [21:0] cw;
        int k;
        logic par;
        cw = 22'h0;
        k  = 0;
        for (int p = 1; p < 22; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            par = 1'b0;
            for (int p = 1; p < 22; p++) begin
                if (((p >> j) & 1) != 0) par = par ^ cw[p];
            end
            cw[1 << j] = par;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic void ref_decode(input logic [21:0] cw, output logic [4:0] syn,
                                       output logic par, output logic [15:0] d);
        int k;
        syn = 5'd0;
        d   = 16'h0;
        k   = 0;
        for (int p = 1; p < 22; p++) begin
            if (cw[p]) syn = syn ^ 5'(p);
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p];
                k++;
            end
        end
        par = ^cw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Input-side tracker: push the expected codeword whenever a word is accepted.
    always @(negedge clk) begin
        logic [21:0] eff;
        exp_t e;
        if (mon_en) begin
            eff = inj_arm ? inj_mask : (pend ? pmask : 22'h0);
            if (valid_in && ready_out) begin
                e.data  = data_in;
                e.cw    = ref_encode(data_in) ^ eff;
                e.clean = (eff == 22'h0);
                sb.push_back(e);
                pend = 1'b0;
            end else if (inj_arm) begin
                pend  = 1'b1;
                pmask = inj_mask;
            end
        end
    end

    // Output-side monitor: pop and compare on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0]  syn;
        logic        par;
        logic [15:0] dd;
        if (mon_en && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(cw_out), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("codeword", 32'(cw_out), 32'(e.cw));
                if (e.clean) begin
                    ref_decode(cw_out, syn, par, dd);
                    check("decode", {10'h0, syn, par, dd}, {10'h0, 5'd0, 1'b0, e.data});
                end
            end
            xfers++;
        end
    end

    task automatic send(input logic [15:0] d);
        bit acc;
        acc      = 1'b0;
        data_in  = d;
        valid_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_out) acc = 1'b1;
            @(posedge clk); #1;
            if (acc) break;
        end
        valid_in = 1'b0;
        if (!acc) fail_now("send_accept");
    endtask

    task automatic drain();
        ready_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!valid_out) break;
            @(posedge clk); #1;
        end
        if (valid_out) fail_now("drain");
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int sent;
        int cyc;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 16'h0;
        ready_in = 1'b0;
        inj_arm  = 1'b0;
        inj_mask = 22'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_cw",    32'(cw_out),    32'd0);
        check("rst_cnt",   32'(cnt_out),   32'd0);
        rst      = 1'b0;
        mon_en   = 1'b1;
        ready_in = 1'b1;

        // Directed vectors and one-cycle latency.
        send(16'h0000);
        check("lat_valid", 32'(valid_out), 32'd1);
        check("cw_0000",   32'(cw_out),    32'h000000);
        @(posedge clk); #1;
        check("cnt_1",     32'(cnt_out),   32'd1);
        send(16'h0001);
        check("cw_0001",   32'(cw_out),    32'h00000F);
        send(16'hFFFF);
        check("cw_FFFF",   32'(cw_out),    32'h3FFFFC);
        @(posedge clk); #1;
        check("cnt_3",     32'(cnt_out),   32'd3);

        // Back-pressure: two absorbed, third held off, order preserved.
        ready_in = 1'b0;
        send(16'h1111);
        send(16'h2222);
        check("bp_ready_low", 32'(ready_out), 32'd0);
        check("bp_head",      32'(cw_out),    32'(ref_encode(16'h1111)));
        data_in  = 16'h3333;
        valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_full", 32'(ready_out), 32'd0);
        check("bp_stable",     32'(cw_out),    32'(ref_encode(16'h1111)));
        check("bp_cnt",        32'(cnt_out),   32'd3);
        ready_in = 1'b1;
        send(16'h3333);
        drain();
        check("bp_cnt_6", 32'(cnt_out), 32'd6);

`ifdef HENC_ERR_INJECT_EN
        // Error injection: one corrupted word, then clean again.
        inj_mask = 22'h000008;
        inj_arm  = 1'b1;
        @(posedge clk); #1;
        inj_arm  = 1'b0;
        send(16'h0001);
        check("inj_cw",   32'(cw_out), 32'h000007);
        send(16'h0001);
        check("inj_next", 32'(cw_out), 32'h00000F);
        drain();
`endif

        // Reset with two words buffered.
        ready_in = 1'b0;
        send(16'hAAAA);
        send(16'h5555);
        check("pre_rst_full", {30'h0, valid_out, ready_out}, 32'b10);
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_cnt",   32'(cnt_out),   32'd0);
        check("arst_cw",    32'(cw_out),    32'd0);
        sb.delete();
        xfers = 0;
        pend  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_ready", 32'(ready_out), 32'd1);
        mon_en = 1'b1;

        // Randomized stream with random back-pressure.
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            ready_in = ($urandom_range(0, 3) != 0);
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 16'($urandom);
            @(negedge clk);
            if (valid_in && ready_out) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        valid_in = 1'b0;
        if (sent < 10000) fail_now("random_stream");
        drain();
        check("rand_xfers", 32'(xfers),   32'd10000);
        check("rand_cnt",   32'(cnt_out), 32'd10000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/h_encoder_22_16.md
# h_encoder_22_16

Streaming Hamming SEC-DED encoder that feeds `h_decoder_22_16`.
- Accepts 16-bit data words over a valid/ready handshake.
- Produces the 22-bit codeword in exactly the bit layout the decoder expects: overall parity at bit 0, check bits at 1/2/4/8/16, data at all other positions.
- Output goes through a 2-entry buffer, so back-pressure from the channel/decoder side never drops words.
- Keeps a running count of emitted codewords.

## Interface
- `DEPTH`, 2: output buffer entries; fixed at 2, not user-changeable.
- `i_Clk`  in  1  clock, all state on rising edge
- `i_Rst`  in  1  asynchronous, active-high reset
- `i_DataWord`  in  16  data word to encode
- `i_Valid`  in  1  `i_DataWord` valid
- `o_Ready`  out  1  encoder can accept; transfer when `i_Valid && o_Ready`
- `o_CodeWord`  out  22  encoded word, head of buffer
- `o_Valid`  out  1  `o_CodeWord` valid
- `i_Ready`  in  1  consumer accepts; transfer when `o_Valid && i_Ready`
- `o_WordCnt`  out  16  number of output transfers, modulo 2^16

## Operation
- Data placement, matching the decoder's extraction:
  - cw[3] = d[0]
  - cw[7:5] = d[3:1]
  - cw[15:9] = d[10:4]
  - cw[21:17] = d[15:11]
- Check bits (even parity):
  - cw[1] = XOR of cw[3,5,7,9,11,13,15,17,19,21]
  - cw[2] = XOR of cw[3,6,7,10,11,14,15,18,19]
  - cw[4] = XOR of cw[5,6,7,12,13,14,15,20,21]
  - cw[8] = XOR of cw[15:9]
  - cw[16] = XOR of cw[21:17]
  - cw[0] = XOR of cw[21:1], computed after all check bits are inserted
- Encode is combinational on the accepted input. The result is written into the buffer in the accept cycle.
- Buffer is a 2-entry FIFO with occupancy `cnt` ∈ {0,1,2}:
  - `o_Valid` = (cnt != 0)
  - `o_Ready` = (cnt != 2), depends only on registered state; there is no combinational path from `i_Ready` to `o_Ready`.
- `cnt` update per cycle:
  - push only: cnt+1
  - pop only: cnt−1
  - push and pop together: cnt unchanged, FIFO order preserved
  - full (cnt=2) with pop: no push that cycle, because `o_Ready` was low
- While `o_Valid && !i_Ready`, `o_CodeWord` holds stable.
- `o_WordCnt` increments on each output transfer and wraps 0xFFFF → 0x0000.

## Timing
- Reset values, applied asynchronously when `i_Rst` asserts:
  - `o_Valid` = 0, `o_CodeWord` = 0, `o_WordCnt` = 0, cnt = 0
  - `o_Ready` = 1 (follows cnt)
- Reset asserted mid-stream discards buffered words. No output transfer occurs in that cycle.
- Latency: a word accepted at edge N is presented on `o_CodeWord` with `o_Valid` = 1 after edge N, i.e. one cycle.
- Throughput: one word per cycle while `i_Ready` is held high.
- With `i_Ready` = 0, at most 2 words are absorbed. `o_Ready` drops in the cycle after the second accept.

## Configuration
- `HENC_ERR_INJECT_EN` defined:
  - Adds ports `i_InjMask` (in, 22) and `i_InjArm` (in, 1).
  - A pulse on `i_InjArm` sets an armed flag and latches the mask.
  - The next accepted word is written as codeword XOR mask, then the flag clears.
  - Arm and accept in the same cycle applies the mask to that word.
  - Reset clears the flag and the mask.
- Undefined: the ports and logic are absent, and codewords are always clean.

## Structure
- Shared package `hamming_22_16_pkg`:
  - widths `DATA_W` = 16, `CODE_W` = 22
  - check-bit position constants (0, 1, 2, 4, 8, 16)
  - a `function` mapping data to codeword
  - the package is also usable by the decoder and the benches
- One sub-module `h_enc_fifo2`: a generic 2-entry valid/ready buffer, parameterised on width. The encoder top holds the encode logic, the counter and the injection logic.

## Test plan
- Reset, then `i_DataWord` = 0x0000 with valid → `o_CodeWord` = 0x000000 one cycle later, `o_WordCnt` = 1.
- `i_DataWord` = 0x0001 → `o_CodeWord` = 0x00000F; `i_DataWord` = 0xFFFF → `o_CodeWord` = 0x3FFFFC.
- `i_Ready` = 0, offer 0x1111, 0x2222, 0x3333 back-to-back:
  - first two accepted, `o_Ready` = 0, 0x3333 held off
  - raise `i_Ready` → codewords emitted in order, no loss or duplication
- Random data, random `i_Ready` for 10k words → each codeword fed to `h_decoder_22_16` returns the original data with `o_ErrorC` = `o_ErrorD` = 0; `o_WordCnt` equals 10000 mod 65536.
- With `HENC_ERR_INJECT_EN`, mask 0x000008 armed, data 0x0001 → `o_CodeWord` = 0x000007 and the decoder reports `o_ErrorC` = 1, data 0x0001; the next word is clean.
- Assert `i_Rst` with 2 words buffered → `o_Valid` = 0 and `o_WordCnt` = 0 immediately; after release `o_Ready` = 1.
